// File: rtl/sine_phase_meas.sv
// sine_phase_meas: measures the ch0 period and the ch1-after-ch0 crossing delay, in samples,
// from two offset-binary sample streams that share one sample strobe.
// One measurement per start; the result is held in DONE until ack.
// Optional build macro SINE_MEAS_HYST_EN: adds per-channel hysteresis arming (HYST margin below
// MID) so that samples dithering around MID do not register as crossings.
module sine_phase_meas #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned C_WIDTH = 10,
    parameter int unsigned MID     = 128
`ifdef SINE_MEAS_HYST_EN
    ,
    parameter int unsigned HYST    = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din0,
    input  logic [D_WIDTH-1:0] din1,
    input  logic               start,
    input  logic               ack,
    output logic               busy,
    output logic               valid,
    output logic [C_WIDTH-1:0] period,
    output logic [C_WIDTH-1:0] phase,
    output logic               tmo
);

    typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

    localparam logic [D_WIDTH-1:0] MidVal = D_WIDTH'(MID);
    localparam logic [C_WIDTH-1:0] CntMax = '1;

    state_e             state_q, state_d;
    logic [C_WIDTH-1:0] cnt_q, cnt_d;
    logic [C_WIDTH-1:0] cnt_nx;
    logic [D_WIDTH-1:0] prev0_q, prev0_d;
    logic [D_WIDTH-1:0] prev1_q, prev1_d;
    logic               prev_ok_q, prev_ok_d;
    logic               seen1_q, seen1_d;
    logic [C_WIDTH-1:0] period_q, period_d;
    logic [C_WIDTH-1:0] phase_q, phase_d;
    logic               tmo_q, tmo_d;
    logic               cross0, cross1;

`ifdef SINE_MEAS_HYST_EN
    localparam logic [D_WIDTH-1:0] ArmLevel = D_WIDTH'(MID - HYST);

    logic arm0_q, arm0_d;
    logic arm1_q, arm1_d;

    // A crossing needs the channel to have been seen clearly below MID since the last crossing.
    always_comb begin
        cross0 = prev_ok_q && arm0_q && (din0 >= MidVal);
        cross1 = prev_ok_q && arm1_q && (din1 >= MidVal);
    end

    // Hysteresis arm bits; cleared on reset and on entry to ARM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm0_q <= 1'b0;
            arm1_q <= 1'b0;
        end else begin
            arm0_q <= arm0_d;
            arm1_q <= arm1_d;
        end
    end
`else
    // Plain rising midscale crossing against the previous en sample.
    always_comb begin
        cross0 = prev_ok_q && (prev0_q < MidVal) && (din0 >= MidVal);
        cross1 = prev_ok_q && (prev1_q < MidVal) && (din1 >= MidVal);
    end
`endif

    assign cnt_nx = cnt_q + C_WIDTH'(1);

    // Next-state logic: handshake, sample tracking, result capture and timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev0_d   = prev0_q;
        prev1_d   = prev1_q;
        prev_ok_d = prev_ok_q;
        seen1_d   = seen1_q;
        period_d  = period_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
`ifdef SINE_MEAS_HYST_EN
        arm0_d    = arm0_q;
        arm1_d    = arm1_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StArm;
                    cnt_d     = '0;
                    tmo_d     = 1'b0;
                    seen1_d   = 1'b0;
                    prev_ok_d = 1'b0;
`ifdef SINE_MEAS_HYST_EN
                    arm0_d    = 1'b0;
                    arm1_d    = 1'b0;
`endif
                end
            end

            StArm, StMeas: begin
                if (en) begin
                    prev0_d   = din0;
                    prev1_d   = din1;
                    prev_ok_d = 1'b1;
`ifdef SINE_MEAS_HYST_EN
                    if (cross0) arm0_d = 1'b0;
                    else if (din0 < ArmLevel) arm0_d = 1'b1;
                    if (cross1) arm1_d = 1'b0;
                    else if (din1 < ArmLevel) arm1_d = 1'b1;
`endif
                    if (state_q == StArm) begin
                        if (cross0) begin
                            // Reference crossing starts the timed window at zero.
                            state_d = StMeas;
                            cnt_d   = '0;
                            if (cross1) begin
                                phase_d = '0;
                                seen1_d = 1'b1;
                            end
                        end else if (cnt_nx == CntMax) begin
                            state_d  = StDone;
                            cnt_d    = cnt_nx;
                            tmo_d    = 1'b1;
                            period_d = '1;
                            phase_d  = '1;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end else begin
                        if (cross1 && !seen1_q) begin
                            phase_d = cnt_nx;
                            seen1_d = 1'b1;
                        end
                        if (cross0) begin
                            // No ch1 crossing inside the period reports phase == period.
                            state_d  = StDone;
                            cnt_d    = cnt_nx;
                            period_d = cnt_nx;
                            if (!seen1_q) phase_d = cnt_nx;
                        end else if (cnt_nx == CntMax) begin
                            state_d  = StDone;
                            cnt_d    = cnt_nx;
                            tmo_d    = 1'b1;
                            period_d = '1;
                            phase_d  = '1;
                        end else begin
                            cnt_d = cnt_nx;
                        end
                    end
                end
            end

            StDone: begin
                if (ack) state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prev0_q   <= '0;
            prev1_q   <= '0;
            prev_ok_q <= 1'b0;
            seen1_q   <= 1'b0;
            period_q  <= '0;
            phase_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev0_q   <= prev0_d;
            prev1_q   <= prev1_d;
            prev_ok_q <= prev_ok_d;
            seen1_q   <= seen1_d;
            period_q  <= period_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
        end
    end

    assign busy   = (state_q == StArm) || (state_q == StMeas);
    assign valid  = (state_q == StDone);
    assign period = period_q;
    assign phase  = phase_q;
    assign tmo    = tmo_q;

endmodule

// File: doc/sine_phase_meas.md
Name: sine_phase_meas

Overview:
- Receive-side companion to the dual-channel sine generator.
- Consumes two sample streams (ch0, ch1) on the same sample strobe the generator uses.
- Detects rising midscale crossings on both channels and measures two quantities:
  - ch0 period, in samples;
  - ch1 crossing delay after ch0, in samples.
- Software-style start/ack handshake; one measurement per start.

Parameters:
D_WIDTH, 8, sample width of din0/din1 (unsigned, offset-binary)
C_WIDTH, 10, width of sample counter, period and phase results
MID, 128, crossing threshold (unsigned compare)
HYST, 4, hysteresis margin, used only with SINE_MEAS_HYST_EN

Ports:
clk    input   1        clock, rising edge
rst    input   1        asynchronous reset, active-low
en     input   1        sample strobe; din0/din1 are meaningful only when en=1
din0   input   D_WIDTH  ch0 sample (reference channel)
din1   input   D_WIDTH  ch1 sample (measured channel)
start  input   1        begin a measurement; accepted only in IDLE
ack    input   1        consume result; accepted only in DONE
busy   output  1        high in ARM and MEAS
valid  output  1        high in DONE
period output  C_WIDTH  samples between consecutive ch0 rising crossings
phase  output  C_WIDTH  samples from ch0 crossing to first ch1 crossing
tmo    output  1        measurement ended by counter saturation

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - busy=0, valid=0, period=0, phase=0, tmo=0.
  - Counter=0, prev regs=0, prev_ok=0.
- Crossing on channel x, evaluated only on en=1 cycles: prev_ok=1 AND prev_x < MID AND din_x >= MID.
- prev_x loads din_x on every en=1 cycle while busy. prev_ok clears on entry to ARM and sets on the first en sample after entry, so the first sample after start never produces a crossing.
- en=0: counter, prev regs and state are frozen (except handshake transitions).
- IDLE:
  - start=1 -> ARM.
  - Clear tmo and ch1-seen flag; counter=0.
  - period/phase hold their previous results until overwritten.
- ARM:
  - Each en sample increments the counter.
  - ch0 crossing -> MEAS, counter=0.
  - If ch1 crosses in that same sample: phase=0 and ch1-seen set.
- MEAS: each en sample, cnt_next = counter+1.
  - ch1 crossing with ch1-seen=0: phase = cnt_next, then set ch1-seen.
  - ch0 crossing: period = cnt_next.
    - If ch1-seen=0, phase = cnt_next (means "no ch1 crossing within one period").
    - Go to DONE.
  - A simultaneous ch0+ch1 crossing with ch1-seen=0 gives phase = period.
- Timeout, in ARM or MEAS: counter equal to 2^C_WIDTH-1 on an en sample without completing forces:
  - tmo=1;
  - period = all ones;
  - phase = all ones;
  - state -> DONE.
  - The counter never wraps.
- DONE:
  - valid=1; results stable.
  - ack=1 -> IDLE next cycle, valid=0.
  - start is ignored while in DONE, including start=1 with ack=1 in the same cycle.
- start in ARM/MEAS is ignored; ack outside DONE is ignored.
- Latency: valid rises one clock after the en sample carrying the closing ch0 crossing.
- Outputs are registered; no combinational input-to-output path.
- Expected results for the generator with phase offset p (256-entry table, step 1):
  - period=256;
  - phase=(256-p) mod 256.

Optional Feature:
- Macro: SINE_MEAS_HYST_EN.
- Defined: the crossing requires the signal to be armed. A per-channel arm bit sets when din_x < MID-HYST and clears when a crossing fires. A crossing is arm=1 AND din_x >= MID, which rejects noise dithering around MID. Arm bits clear on reset and on ARM entry.
- Not defined: plain threshold compare as above; HYST is unused and no arm registers are synthesized.

Test Plan:
1. Generator p=0 drives din0/din1, en=1 every cycle, start pulse -> valid after one full period; period=256, phase=0, tmo=0.
2. p=64 -> period=256, phase=192. ack -> valid=0 next cycle; results held in IDLE.
3. din0 toggles sine, din1 held at 0x00 -> period=256, phase=256 (no ch1 crossing), tmo=0.
4. din0 held at 0x40, start -> after 1023 en samples tmo=1, period=0x3FF, phase=0x3FF, valid=1.
5. en asserted every 3rd cycle with p=32 -> period=256, phase=224; state frozen on en=0 cycles. Drive rst low mid-MEAS -> busy=0, valid=0, outputs 0 immediately (asynchronous).
6. With SINE_MEAS_HYST_EN, din0 dithers 127/128 for 20 samples before a clean sine -> no crossings during the dither; period=256. Without the macro the dither closes the measurement early (period=2).
